// File: rtl/mac_pkg.sv
// Shared types and constants for the signed multiply-accumulate slice.
// Default widths, accumulator limits and sideband bundle.
package mac_pkg;

    localparam int WIDTH_DEF       = 14;
    localparam int MULT_STAGES_DEF = 4;
    localparam int ACC_W           = 2 * WIDTH_DEF;

    localparam logic signed [ACC_W-1:0] ACC_MAX =
        {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN =
        {1'b1, {(ACC_W-1){1'b0}}};

    typedef logic signed [WIDTH_DEF-1:0] operand_t;
    typedef logic signed [ACC_W-1:0]     acc_t;

    // Control that travels alongside each product through the multiplier.
    typedef struct packed {
        logic valid;
        logic clr;
    } side_t;

    // A wide sum overflowed when its two top bits disagree.
    function automatic logic sign_mismatch(
        input logic top,
        input logic next
    );
        return top ^ next;
    endfunction

endpackage

// File: rtl/mac_pipe_acc_mult_pipe.sv
// Registered signed multiplier with a valid/clr sideband shift register.
// Stage 0 registers the full-width product; later stages only delay it.
module mult_pipe
    import mac_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int STAGES = MULT_STAGES_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic signed [WIDTH-1:0]   a,
    input  logic signed [WIDTH-1:0]   b,
    input  logic                      valid_in,
    input  logic                      clr_in,
    output logic signed [2*WIDTH-1:0] p,
    output logic                      valid_out,
    output logic                      clr_out
);

    localparam int PW = 2 * WIDTH;

    logic signed [PW-1:0] a_x;
    logic signed [PW-1:0] b_x;

    logic signed [PW-1:0] p_d [STAGES];
    logic signed [PW-1:0] p_q [STAGES];
    side_t                side_d [STAGES];
    side_t                side_q [STAGES];

    // Sign-extend operands so the product is computed at full width.
    always_comb begin
        a_x = $signed({{WIDTH{a[WIDTH-1]}}, a});
        b_x = $signed({{WIDTH{b[WIDTH-1]}}, b});
    end

    // Next-state for every stage: multiply at the head, shift the rest.
    always_comb begin
        p_d[0]          = a_x * b_x;
        side_d[0].valid = valid_in;
        side_d[0].clr   = clr_in;
        for (int i = 1; i < STAGES; i++) begin
            p_d[i]    = p_q[i-1];
            side_d[i] = side_q[i-1];
        end
    end

    // Pipeline registers; reset drops every in-flight sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < STAGES; i++) begin
                p_q[i]    <= '0;
                side_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                p_q[i]    <= p_d[i];
                side_q[i] <= side_d[i];
            end
        end
    end

    assign p         = p_q[STAGES-1];
    assign valid_out = side_q[STAGES-1].valid;
    assign clr_out   = side_q[STAGES-1].clr;

endmodule

// File: rtl/mac_pipe_acc.sv
// Signed multiply-accumulate engine: input regs, pipelined multiplier,
// and a wrap-or-saturate accumulate stage producing f/valid_out/overflow.
module mac_pipe_acc
    import mac_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int MULT_STAGES = MULT_STAGES_DEF,
    parameter bit SATURATE    = 1'b0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic signed [WIDTH-1:0]   a,
    input  logic signed [WIDTH-1:0]   b,
    input  logic                      valid_in,
    input  logic                      clr_acc,
    output logic signed [2*WIDTH-1:0] f,
    output logic                      valid_out,
    output logic                      overflow
);

    localparam int AW = 2 * WIDTH;

    localparam logic signed [AW-1:0] F_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] F_MIN = {1'b1, {(AW-1){1'b0}}};

    logic signed [WIDTH-1:0] a_d;
    logic signed [WIDTH-1:0] a_q;
    logic signed [WIDTH-1:0] b_d;
    logic signed [WIDTH-1:0] b_q;
    logic                    vin_d;
    logic                    vin_q;
    logic                    clr_d;
    logic                    clr_q;

    logic signed [AW-1:0] prod;
    logic                 prod_valid;
    logic                 prod_clr;

    logic signed [AW:0]   sum_w;
    logic                 sum_ovf;

    logic signed [AW-1:0] f_d;
    logic signed [AW-1:0] f_q;
    logic                 vout_d;
    logic                 vout_q;
    logic                 ovf_d;
    logic                 ovf_q;

    // Capture the operand bundle every cycle; there is no back-pressure.
    always_comb begin
        a_d   = a;
        b_d   = b;
        vin_d = valid_in;
        clr_d = clr_acc;
    end

    // Input registers; the valid bit is what reset must clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q   <= '0;
            b_q   <= '0;
            vin_q <= 1'b0;
            clr_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            vin_q <= vin_d;
            clr_q <= clr_d;
        end
    end

    mult_pipe #(
        .WIDTH  (WIDTH),
        .STAGES (MULT_STAGES)
    ) u_mult (
        .clk       (clk),
        .reset     (reset),
        .a         (a_q),
        .b         (b_q),
        .valid_in  (vin_q),
        .clr_in    (clr_q),
        .p         (prod),
        .valid_out (prod_valid),
        .clr_out   (prod_clr)
    );

    // One extra bit of headroom exposes wrap as a sign disagreement.
    always_comb begin
        sum_w   = $signed({f_q[AW-1], f_q}) + $signed({prod[AW-1], prod});
        sum_ovf = sign_mismatch(sum_w[AW], sum_w[AW-1]);
    end

    // Accumulate next-state: restart, wrap or clamp; bubbles hold f.
    always_comb begin
        f_d    = f_q;
        vout_d = 1'b0;
        ovf_d  = 1'b0;
        if (prod_valid) begin
            vout_d = 1'b1;
            if (prod_clr) begin
                f_d = prod;
            end else if (SATURATE && sum_ovf) begin
                f_d   = sum_w[AW] ? F_MIN : F_MAX;
                ovf_d = 1'b1;
            end else begin
                f_d   = sum_w[AW-1:0];
                ovf_d = sum_ovf;
            end
        end
    end

    // Result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f_q    <= '0;
            vout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            f_q    <= f_d;
            vout_q <= vout_d;
            ovf_q  <= ovf_d;
        end
    end

    assign f         = f_q;
    assign valid_out = vout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_mac_pipe_acc.sv
// Randomised bench for mac_pipe_acc against a cycle-indexed history model.
// Literal pins on selected samples anchor the model itself.
module tb_mac_pipe_acc;

    localparam int W    = 14;
    localparam int S    = 4;
    localparam int AW   = 2 * W;
    localparam bit SAT  = 1'b0;
    localparam int HMAX = 8192;
    localparam longint FMAX = (64'sd1 <<< (AW - 1)) - 1;
    localparam longint FMIN = -(64'sd1 <<< (AW - 1));

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic signed [W-1:0]  a = '0;
    logic signed [W-1:0]  b = '0;
    logic                 valid_in = 1'b0;
    logic                 clr_acc = 1'b0;
    logic signed [AW-1:0] f;
    logic                 valid_out;
    logic                 overflow;

    int tests = 0;
    int fails = 0;

    int     cyc = 0;
    bit     h_v   [HMAX];
    bit     h_c   [HMAX];
    int     h_a   [HMAX];
    int     h_b   [HMAX];
    bit     h_pin [HMAX];
    longint h_pf  [HMAX];
    bit     h_pov [HMAX];

    bit     cur_pin = 0;
    longint cur_pf  = 0;
    bit     cur_pov = 0;

    longint mf = 0;

    mac_pipe_acc #(
        .WIDTH       (W),
        .MULT_STAGES (S),
        .SATURATE    (SAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .a         (a),
        .b         (b),
        .valid_in  (valid_in),
        .clr_acc   (clr_acc),
        .f         (f),
        .valid_out (valid_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Record what the DUT captures on each edge.
    always @(posedge clk) begin
        h_v[cyc]   = valid_in && reset;
        h_c[cyc]   = clr_acc;
        h_a[cyc]   = int'(a);
        h_b[cyc]   = int'(b);
        h_pin[cyc] = cur_pin;
        h_pf[cyc]  = cur_pf;
        h_pov[cyc] = cur_pov;
        cyc++;
    end

    // Model and compare on the falling edge.
    always @(negedge clk) begin
        int     idx;
        bit     ev;
        bit     eov;
        longint p;
        longint w;
        logic signed [AW-1:0] wr;
        if (!reset) begin
            mf = 0;
            for (int j = (cyc > S + 3 ? cyc - S - 3 : 0); j < cyc; j++)
                h_v[j] = 0;
            check("reset_f", longint'(f), 0);
            check("reset_valid_out", longint'(valid_out), 0);
            check("reset_overflow", longint'(overflow), 0);
        end else begin
            idx = cyc - S - 2;
            ev  = 0;
            eov = 0;
            if (idx >= 0 && h_v[idx]) begin
                ev = 1;
                p  = longint'(h_a[idx]) * longint'(h_b[idx]);
                if (h_c[idx]) begin
                    mf = p;
                end else begin
                    w = mf + p;
                    if (w > FMAX || w < FMIN) begin
                        eov = 1;
                        if (SAT) begin
                            mf = (w > FMAX) ? FMAX : FMIN;
                        end else begin
                            wr = w[AW-1:0];
                            mf = longint'(wr);
                        end
                    end else begin
                        mf = w;
                    end
                end
            end
            check("valid_out", longint'(valid_out), longint'(ev));
            check("f", longint'(f), mf);
            check("overflow", longint'(overflow), longint'(eov));
            if (ev && h_pin[idx]) begin
                check("pin_model_f", mf, h_pf[idx]);
                check("pin_dut_f", longint'(f), h_pf[idx]);
                check("pin_overflow", longint'(overflow), longint'(h_pov[idx]));
            end
        end
    end

    // Drive one cycle of inputs, optionally pinning its expected result.
    task automatic step(input bit v, input bit c, input int ai, input int bi,
                        input bit pin = 0, input longint pf = 0, input bit pov = 0);
        valid_in = v;
        clr_acc  = c;
        a        = ai[W-1:0];
        b        = bi[W-1:0];
        cur_pin  = pin;
        cur_pf   = pf;
        cur_pov  = pov;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(0, $urandom_range(0, 1), $urandom, $urandom);
    endtask

    task automatic rand_run(input int n);
        int ra;
        int rb;
        for (int i = 0; i < n; i++) begin
            ra = int'($urandom);
            rb = int'($urandom);
            if ($urandom_range(0, 3) == 0) ra = -8192;
            if ($urandom_range(0, 3) == 0) rb = ($urandom_range(0, 1) != 0) ? -8192 : 8191;
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, ra, rb);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;

        step(1, 1, 3, 4, 1, 12, 0);
        step(1, 0, -5, 2, 1, 2, 0);
        idle(10);
        idle(S + 2);
        check("bubble_hold_f", longint'(f), 2);

        for (int i = 0; i < 10; i++)
            step(1, i == 0, i, 1, 1, longint'(i * (i + 1) / 2), 0);
        step(1, 1, 7, -3, 1, -21, 0);
        step(1, 0, 1, 1, 1, -20, 0);

        step(1, 1, -8192, -8192, 1, 67108864, 0);
        step(1, 0, -8192, -8192, 1, -134217728, 1);
        step(1, 0, -8192, -8192, 1, -67108864, 0);
        idle(S + 3);
        check("overflow_final_f", longint'(f), -67108864);

        rand_run(300);

        step(1, 1, 5, 5);
        step(1, 0, 6, 6);
        valid_in = 1'b1;
        a = 14'sd9;
        b = 14'sd9;
        #3;
        reset   = 1'b0;
        valid_in = 1'b0;
        #1;
        check("async_reset_f", longint'(f), 0);
        check("async_reset_vout", longint'(valid_out), 0);
        @(posedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        idle(S + 4);
        step(1, 0, 2, 5, 1, 10, 0);
        step(1, 0, -1, 3, 1, 7, 0);

        rand_run(300);
        idle(S + 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
